// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: write-back arbiter that owns the register-file write port.
// Merges pipeline write-back, interrupt PC save (x30) and a buffered
// auxiliary queue into at most one registered write per cycle.
// Fixed priority: PIPE > ISR > AUX FIFO head.
// Optional build macro WB_PENDING_EN adds a per-register pending scoreboard
// and the PENDING_MASK output; without it neither exists.
module reg_wb_arbiter #(
    parameter int AUX_DEPTH = 4,
    parameter int AW        = $clog2(AUX_DEPTH)
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PIPE_VALID,
    input  logic [4:0]  PIPE_ADDR,
    input  logic [31:0] PIPE_DATA,
    input  logic        ISR_REQ,
    input  logic [31:0] ISR_PC,
    output logic        ISR_ACK,
    input  logic        AUX_VALID,
    output logic        AUX_READY,
    input  logic [4:0]  AUX_ADDR,
    input  logic [31:0] AUX_DATA,
    output logic [AW:0] AUX_COUNT,
    output logic [31:0] REG_IN,
    output logic [4:0]  REG_INADDRESS,
    output logic        REG_WRITE_EN
`ifdef WB_PENDING_EN
    ,
    output logic [31:0] PENDING_MASK
`endif
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(AUX_DEPTH);
    localparam logic [4:0]  ISR_REG   = 5'd30;

    logic [4:0]    fifo_addr [AUX_DEPTH];
    logic [31:0]   fifo_data [AUX_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic [4:0]    head_addr;

    logic          wr_vld_p0;
    logic [4:0]    wr_addr_p0;
    logic [31:0]   wr_data_p0;
    logic          isr_ack_p0;

    logic          wr_en_p1;
    logic [4:0]    wr_addr_p1;
    logic [31:0]   wr_data_p1;
    logic          isr_ack_p1;

    // AUX_READY looks only at occupancy, never at a same-cycle pop.
    assign AUX_READY = !RESET && (count < DEPTH_CNT);
    assign push      = AUX_VALID && AUX_READY;
    // A freshly pushed entry into an empty FIFO is not visible until next cycle.
    assign pop       = (count != '0) && !PIPE_VALID && !ISR_REQ;
    assign head_addr = fifo_addr[rd_ptr];
    assign AUX_COUNT = count;

    // Grant selection: pick at most one source by fixed priority.
    always_comb begin
        wr_vld_p0  = 1'b0;
        wr_addr_p0 = '0;
        wr_data_p0 = '0;
        isr_ack_p0 = 1'b0;
        if (PIPE_VALID) begin
            wr_vld_p0  = 1'b1;
            wr_addr_p0 = PIPE_ADDR;
            wr_data_p0 = PIPE_DATA;
        end else if (ISR_REQ) begin
            wr_vld_p0  = 1'b1;
            wr_addr_p0 = ISR_REG;
            wr_data_p0 = ISR_PC;
            isr_ack_p0 = 1'b1;
        end else if (pop) begin
            wr_vld_p0  = 1'b1;
            wr_addr_p0 = head_addr;
            wr_data_p0 = fifo_data[rd_ptr];
        end
    end

    // ---- stage p0 -> p1: registered write port ----
    // Register the granted write; x0 is consumed without asserting the enable.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_en_p1   <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
            isr_ack_p1 <= 1'b0;
        end else begin
            wr_en_p1   <= wr_vld_p0 && (wr_addr_p0 != 5'd0);
            isr_ack_p1 <= isr_ack_p0;
            if (wr_vld_p0) begin
                wr_addr_p1 <= wr_addr_p0;
                wr_data_p1 <= wr_data_p0;
            end
        end
    end

    assign REG_WRITE_EN  = wr_en_p1;
    assign REG_INADDRESS = wr_addr_p1;
    assign REG_IN        = wr_data_p1;
    assign ISR_ACK       = isr_ack_p1;

    // FIFO storage: written on push, no reset needed for payload.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_addr[wr_ptr] <= AUX_ADDR;
            fifo_data[wr_ptr] <= AUX_DATA;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at AUX_DEPTH.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

`ifdef WB_PENDING_EN
    logic [AW:0] pend_cnt [32];

    // Per-register count of queued entries; x0 is never tracked.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 32; i++) pend_cnt[i] <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if ((push && AUX_ADDR == 5'(i)) && !(pop && head_addr == 5'(i)))
                    pend_cnt[i] <= pend_cnt[i] + 1'b1;
                else if ((pop && head_addr == 5'(i)) && !(push && AUX_ADDR == 5'(i)))
                    pend_cnt[i] <= pend_cnt[i] - 1'b1;
            end
        end
    end

    // A register is pending while any queued entry targets it.
    always_comb begin
        PENDING_MASK = '0;
        for (int i = 1; i < 32; i++) PENDING_MASK[i] = (pend_cnt[i] != '0);
    end
`endif

endmodule
